aes_128_key_bank: RTL and testbench
===================================

# aes_128_key_bank

Parametrised multi-set key store for the AES-128 core. It generalises the fixed one-key/two-key load modes to `KEY_SETS` independent 128-bit key slots. Each slot is written through a narrow word bus into a shadow register and committed atomically. Per-block key selection gives the cipher datapath a registered key plus a set tag. It sits between the host write port and `aes_128_top`'s key-expansion input.

## Interface
- `KEY_SETS`, 2, number of key slots (1..16)
- `BUS_W`, 32, key write word width; must divide 128 (8/16/32/64/128)
- `SET_W`, derived max(1,$clog2(KEY_SETS)), set index width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `key_wr_en` in 1: key word write strobe
- `key_wr_set` in SET_W: target slot for current word
- `key_wr_data` in BUS_W: key word, most-significant word first
- `key_wr_ready` out 1: word accepted when `key_wr_en & key_wr_ready`
- `blk_valid` in 1: data block requests a key
- `blk_set` in SET_W: requested slot
- `blk_ready` out 1: request accepted when `blk_valid & blk_ready`
- `key_vld` out 1: `key_out`/`key_set_out` valid (one-cycle pulse per request)
- `key_out` out 128: selected key
- `key_set_out` out SET_W: slot of `key_out`
- `key_err` out 1: pulse; requested slot never loaded or out of range
- `key_clr` in 1: zeroize request (present only with `AES_KEY_BANK_ZEROIZE_EN`)

## Operation
- Write FSM: IDLE, FILL, COMMIT. Words per key `W = 128/BUS_W`, word counter `0..W-1`.
- IDLE: accepted word loads shadow bits `[127 -: BUS_W]`, latches set, counter=1, -> FILL (W=1: -> COMMIT directly).
- FILL: accepted word with same set shifts into shadow, counter++; on word W-1 -> COMMIT.
- FILL, accepted word with different `key_wr_set`: partial key discarded, word treated as the first word of the new set.
- COMMIT: `key_wr_ready=0`; shadow copied to slot, slot valid flag set, -> IDLE. If an accepted block request targets the committing slot in that cycle, commit stalls one cycle; that request receives the old key.
- Write to `key_wr_set >= KEY_SETS`: word accepted and dropped; FSM stays/returns IDLE.
- Select: accepted request registers `key_out <= slot[blk_set]`, `key_set_out <= blk_set`, `key_vld <= 1`. Unloaded or out-of-range slot: `key_out <= 0`, `key_vld <= 1`, `key_err <= 1`.
- `blk_ready` is 1 except during an active `key_clr` cycle. Back-to-back requests are serviced every cycle.

## Timing
- Reset values: `key_wr_ready=1`, `blk_ready=1`, `key_vld=0`, `key_err=0`, `key_out=0`, `key_set_out=0`; FSM IDLE, counter 0, shadow, all slots and valid flags cleared.
- Reset mid-write discards the partial key. Reset mid-commit leaves the slot invalid.
- Select latency: 1 cycle from handshake to `key_vld`.
- Load latency: last word accepted at cycle N; slot usable by a request at N+2; stalled commit at N+3.
- `key_wr_ready` low exactly one cycle per commit (two if stalled).

## Configuration
- `AES_KEY_BANK_ZEROIZE_EN` defined: `key_clr` port exists. A high `key_clr` cycle synchronously zeroes all slots, valid flags and the shadow, and forces the FSM to IDLE. During that cycle `blk_ready=0`, `key_wr_ready=0`, and no `key_vld` is issued. `key_clr` takes priority over a simultaneous write or commit.
- Undefined: no `key_clr` port; keys are cleared only by `rst_n`.

## Test plan
- KEY_SETS=2, BUS_W=32: write slot 0 with `00010203,04050607,08090a0b,0c0d0e0f`, request set 0 two cycles later -> `key_vld=1`, `key_out=000102030405060708090a0b0c0d0e0f`, `key_set_out=0`, `key_err=0`.
- Request slot 1 before loading it -> `key_vld=1`, `key_err=1`, `key_out=0`.
- Load slot 1 with `2b7e1516...09cf4f3c`; alternate set 0/1 requests on consecutive cycles -> keys alternate each cycle, no bubbles.
- Write two words to slot 0, then four words to slot 1 -> slot 0 keeps its old key; slot 1 holds the new key.
- Request slot 0 in its COMMIT cycle -> the old key is returned, `key_wr_ready` is low for 2 cycles, and the next request returns the new key.
- With `AES_KEY_BANK_ZEROIZE_EN`: load both slots, pulse `key_clr`, request each slot -> `key_err=1` for both. Assert `rst_n` low mid-FILL -> all outputs at reset values.

Source files
------------

// File: rtl/aes_128_key_bank.sv
// ---------------------------------------------------------------------------
// aes_128_key_bank
//
// Multi-slot key store in front of the AES-128 key-expansion input.
// The host writes a 128-bit key as 128/BUS_W words, most-significant word
// first, into a shadow register. The completed key is then committed
// atomically into one of KEY_SETS slots. For each data block, a request
// selects a slot, and the key bank returns the registered key and the set tag.
//
// Optional feature macro: AES_KEY_BANK_ZEROIZE_EN
//   When defined, the module has a key_clr port. Driving key_clr high for one
//   cycle synchronously zeroes every slot, every valid flag and the shadow
//   register, and forces the write FSM back to IDLE. When the macro is not
//   defined, only rst_n clears the keys.
//
// Ports:
//   clk, rst_n     : rising-edge clock, asynchronous active-low reset
//   key_wr_en      : key word write strobe
//   key_wr_set     : target slot for the current word
//   key_wr_data    : key word (most-significant word first)
//   key_wr_ready   : a word is accepted when key_wr_en & key_wr_ready
//   blk_valid      : a data block requests a key
//   blk_set        : requested slot
//   blk_ready      : a request is accepted when blk_valid & blk_ready
//   key_vld        : one-cycle pulse, key_out/key_set_out valid
//   key_out        : selected key (zero on error)
//   key_set_out    : slot tag of key_out
//   key_err        : pulse; the requested slot was never loaded or is
//                    out of range
//   key_clr        : zeroize request (only with AES_KEY_BANK_ZEROIZE_EN)
// ---------------------------------------------------------------------------
module aes_128_key_bank #(
  parameter int KEY_SETS = 2,
  parameter int BUS_W    = 32,
  parameter int SET_W    = (KEY_SETS > 1) ? $clog2(KEY_SETS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_wr_en,
  input  logic [SET_W-1:0]  key_wr_set,
  input  logic [BUS_W-1:0]  key_wr_data,
  output logic              key_wr_ready,
  input  logic              blk_valid,
  input  logic [SET_W-1:0]  blk_set,
  output logic              blk_ready,
  output logic              key_vld,
  output logic [127:0]      key_out,
  output logic [SET_W-1:0]  key_set_out,
  output logic              key_err
`ifdef AES_KEY_BANK_ZEROIZE_EN
  ,
  input  logic              key_clr
`endif
);

  localparam int W     = 128 / BUS_W;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [SET_W:0]   NSETS    = (SET_W+1)'(KEY_SETS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [SET_W-1:0]    r_wset;
  logic [127:0]        r_shadow;
  logic                r_stalled;
  logic [127:0]        r_slot [KEY_SETS];
  logic [KEY_SETS-1:0] r_valid;
  logic                r_key_vld;
  logic                r_key_err;
  logic [127:0]        r_key_out;
  logic [SET_W-1:0]    r_key_set_out;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [SET_W-1:0]    w_wset_nxt;
  logic [127:0]        w_shadow_nxt;
  logic                w_stalled_nxt;
  logic                w_clr;
  logic                w_wr_acc;
  logic                w_blk_acc;
  logic                w_wr_inrange;
  logic                w_commit_hit;
  logic                w_commit_do;
  logic [127:0]        w_sel_key;
  logic                w_sel_hit;

`ifdef AES_KEY_BANK_ZEROIZE_EN
  assign w_clr = key_clr;
`else
  assign w_clr = 1'b0;
`endif

  assign key_wr_ready = (r_state != S_COMMIT) & ~w_clr;
  assign blk_ready    = ~w_clr;
  assign key_vld      = r_key_vld;
  assign key_err      = r_key_err;
  assign key_out      = r_key_out;
  assign key_set_out  = r_key_set_out;

  assign w_wr_acc     = key_wr_en & key_wr_ready;
  assign w_blk_acc    = blk_valid & blk_ready;
  assign w_wr_inrange = ({1'b0, key_wr_set} < NSETS);

  // A request hitting the committing slot defers the commit by one cycle,
  // so that the request still sees the old key. This deferral happens at most
  // once, which bounds the time key_wr_ready stays low.
  assign w_commit_hit = w_blk_acc & (blk_set == r_wset) & ~r_stalled;
  assign w_commit_do  = (r_state == S_COMMIT) & ~w_commit_hit & ~w_clr;

  // Slot lookup for block requests. An out-of-range or unloaded slot yields
  // a miss and a zero key.
  always_comb begin
    w_sel_key = 128'd0;
    w_sel_hit = 1'b0;
    for (int i = 0; i < KEY_SETS; i++) begin
      w_sel_key = w_sel_key |
                  ({128{(blk_set == SET_W'(i)) & r_valid[i]}} & r_slot[i]);
      w_sel_hit = w_sel_hit | ((blk_set == SET_W'(i)) & r_valid[i]);
    end
  end

  // Write FSM next-state and shadow assembly.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_wset_nxt    = r_wset;
    w_shadow_nxt  = r_shadow;
    w_stalled_nxt = 1'b0;
    if (w_clr) begin
      w_state_nxt  = S_IDLE;
      w_cnt_nxt    = {CNT_W{1'b0}};
      w_shadow_nxt = 128'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wr_acc && w_wr_inrange) begin
            w_shadow_nxt[127 -: BUS_W] = key_wr_data;
            w_wset_nxt  = key_wr_set;
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = (W == 1) ? S_COMMIT : S_FILL;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_FILL: begin
          if (!w_wr_acc) begin
            w_state_nxt = S_FILL;
          end else if (!w_wr_inrange) begin
            // Word for a nonexistent slot: drop it together with the
            // partial key.
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = {CNT_W{1'b0}};
          end else if (key_wr_set != r_wset) begin
            // When the set changes mid-key, restart with this word as the
            // first word of the new set.
            w_shadow_nxt[127 -: BUS_W] = key_wr_data;
            w_wset_nxt  = key_wr_set;
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = S_FILL;
          end else begin
            w_shadow_nxt[127 - int'(r_cnt) * BUS_W -: BUS_W] = key_wr_data;
            if (r_cnt == LAST_CNT) begin
              w_cnt_nxt   = {CNT_W{1'b0}};
              w_state_nxt = S_COMMIT;
            end else begin
              w_cnt_nxt   = r_cnt + CNT_W'(1);
              w_state_nxt = S_FILL;
            end
          end
        end
        S_COMMIT: begin
          if (w_commit_hit) begin
            w_stalled_nxt = 1'b1;
            w_state_nxt   = S_COMMIT;
          end else begin
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Write FSM state, counter, latched set and shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= {CNT_W{1'b0}};
      r_wset    <= {SET_W{1'b0}};
      r_shadow  <= 128'd0;
      r_stalled <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wset    <= w_wset_nxt;
      r_shadow  <= w_shadow_nxt;
      r_stalled <= w_stalled_nxt;
    end
  end

  // Key slots and valid flags: atomic commit from the shadow, plus zeroize.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KEY_SETS; i++) begin
        r_slot[i] <= 128'd0;
      end
      r_valid <= {KEY_SETS{1'b0}};
    end else if (w_clr) begin
      for (int i = 0; i < KEY_SETS; i++) begin
        r_slot[i] <= 128'd0;
      end
      r_valid <= {KEY_SETS{1'b0}};
    end else if (w_commit_do) begin
      for (int i = 0; i < KEY_SETS; i++) begin
        if (r_wset == SET_W'(i)) begin
          r_slot[i]  <= r_shadow;
          r_valid[i] <= 1'b1;
        end
      end
    end
  end

  // Registered key-select outputs; key_vld and key_err are single-cycle
  // pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_vld     <= 1'b0;
      r_key_err     <= 1'b0;
      r_key_out     <= 128'd0;
      r_key_set_out <= {SET_W{1'b0}};
    end else if (w_blk_acc) begin
      r_key_vld     <= 1'b1;
      r_key_err     <= ~w_sel_hit;
      r_key_out     <= w_sel_key;
      r_key_set_out <= blk_set;
    end else begin
      r_key_vld <= 1'b0;
      r_key_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_128_key_bank.sv
// Directed testbench for aes_128_key_bank with KEY_SETS=2 and BUS_W=32.
module tb_aes_128_key_bank;

  localparam int KEY_SETS = 2;
  localparam int BUS_W    = 32;
  localparam int SET_W    = 1;

  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] K3 = 128'h00112233445566778899aabbccddeeff;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             key_wr_en;
  logic [SET_W-1:0] key_wr_set;
  logic [BUS_W-1:0] key_wr_data;
  logic             key_wr_ready;
  logic             blk_valid;
  logic [SET_W-1:0] blk_set;
  logic             blk_ready;
  logic             key_vld;
  logic [127:0]     key_out;
  logic [SET_W-1:0] key_set_out;
  logic             key_err;
`ifdef AES_KEY_BANK_ZEROIZE_EN
  logic             key_clr;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aes_128_key_bank #(.KEY_SETS(KEY_SETS), .BUS_W(BUS_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_wr_en    (key_wr_en),
    .key_wr_set   (key_wr_set),
    .key_wr_data  (key_wr_data),
    .key_wr_ready (key_wr_ready),
    .blk_valid    (blk_valid),
    .blk_set      (blk_set),
    .blk_ready    (blk_ready),
    .key_vld      (key_vld),
    .key_out      (key_out),
    .key_set_out  (key_set_out),
    .key_err      (key_err)
`ifdef AES_KEY_BANK_ZEROIZE_EN
    ,
    .key_clr      (key_clr)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic s, input logic [31:0] d);
    chk("wr_ready_before_word", {127'd0, key_wr_ready}, 128'd1);
    key_wr_en   = 1'b1;
    key_wr_set  = s;
    key_wr_data = d;
    tick();
    key_wr_en   = 1'b0;
  endtask

  task automatic write_key(input logic s, input logic [127:0] k);
    for (int i = 0; i < 4; i++) begin
      wr_word(s, k[127 - 32*i -: 32]);
    end
  endtask

  task automatic req(input logic s);
    blk_valid = 1'b1;
    blk_set   = s;
    tick();
    blk_valid = 1'b0;
  endtask

  task automatic chk_key(input string tag, input logic s, input logic [127:0] k, input logic e);
    chk({tag, "_vld"}, {127'd0, key_vld}, 128'd1);
    chk({tag, "_key"}, key_out, k);
    chk({tag, "_set"}, {127'd0, key_set_out}, {127'd0, s});
    chk({tag, "_err"}, {127'd0, key_err}, {127'd0, e});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_ready"}, {127'd0, key_wr_ready}, 128'd1);
    chk({tag, "_blk_ready"}, {127'd0, blk_ready}, 128'd1);
    chk({tag, "_vld"}, {127'd0, key_vld}, 128'd0);
    chk({tag, "_err"}, {127'd0, key_err}, 128'd0);
    chk({tag, "_key"}, key_out, 128'd0);
    chk({tag, "_set"}, {127'd0, key_set_out}, 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    key_wr_en   = 1'b0;
    key_wr_set  = 1'b0;
    key_wr_data = 32'd0;
    blk_valid   = 1'b0;
    blk_set     = 1'b0;
`ifdef AES_KEY_BANK_ZEROIZE_EN
    key_clr     = 1'b0;
`endif
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Load slot 0; the commit cycle holds key_wr_ready low for one cycle
    write_key(1'b0, K0);
    chk("commit_wr_ready_low", {127'd0, key_wr_ready}, 128'd0);
    tick();
    chk("commit_wr_ready_high", {127'd0, key_wr_ready}, 128'd1);
    req(1'b0);
    chk_key("slot0_load", 1'b0, K0, 1'b0);
    tick();
    chk("vld_pulse_end", {127'd0, key_vld}, 128'd0);

    // Request an unloaded slot
    req(1'b1);
    chk_key("slot1_unloaded", 1'b1, 128'd0, 1'b1);
    tick();
    chk("err_pulse_end", {127'd0, key_err}, 128'd0);

    // Load slot 1, then alternate requests back-to-back
    write_key(1'b1, K1);
    tick();
    for (int j = 0; j < 4; j++) begin
      blk_valid = 1'b1;
      blk_set   = j[0];
      tick();
      chk_key("alternate", j[0], j[0] ? K1 : K0, 1'b0);
    end
    blk_valid = 1'b0;

    // A partial slot-0 key is abandoned when slot-1 words arrive
    wr_word(1'b0, K2[127:96]);
    wr_word(1'b0, K2[95:64]);
    write_key(1'b1, K3);
    tick();
    req(1'b0);
    chk_key("abandon_slot0", 1'b0, K0, 1'b0);
    req(1'b1);
    chk_key("abandon_slot1", 1'b1, K3, 1'b0);

    // A request during COMMIT for the same slot stalls the commit
    write_key(1'b0, K2);
    chk("stall_wr_ready_c1", {127'd0, key_wr_ready}, 128'd0);
    req(1'b0);
    chk_key("stall_old_key", 1'b0, K0, 1'b0);
    chk("stall_wr_ready_c2", {127'd0, key_wr_ready}, 128'd0);
    tick();
    chk("stall_wr_ready_c3", {127'd0, key_wr_ready}, 128'd1);
    req(1'b0);
    chk_key("stall_new_key", 1'b0, K2, 1'b0);

    // Apply reset in the middle of FILL
    wr_word(1'b1, K2[127:96]);
    wr_word(1'b1, K2[95:64]);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midfill_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    req(1'b0);
    chk_key("after_reset_slot0", 1'b0, 128'd0, 1'b1);
    write_key(1'b1, K1);
    tick();
    req(1'b1);
    chk_key("after_reset_reload", 1'b1, K1, 1'b0);

`ifdef AES_KEY_BANK_ZEROIZE_EN
    write_key(1'b0, K0);
    tick();
    key_clr   = 1'b1;
    blk_valid = 1'b1;
    blk_set   = 1'b0;
    #1;
    chk("clr_blk_ready", {127'd0, blk_ready}, 128'd0);
    chk("clr_wr_ready", {127'd0, key_wr_ready}, 128'd0);
    tick();
    chk("clr_no_vld", {127'd0, key_vld}, 128'd0);
    key_clr   = 1'b0;
    blk_valid = 1'b0;
    req(1'b0);
    chk_key("clr_slot0", 1'b0, 128'd0, 1'b1);
    req(1'b1);
    chk_key("clr_slot1", 1'b1, 128'd0, 1'b1);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
